adder_tree_acc_seq: RTL

- Parametrised successor to the two-input sequential adder: a pipelined signed adder tree over NUM_INPUTS lanes, with an optional accumulate-over-beats output stage.
- Sits between the multiplier array and writeback in the reduction datapath.
- Reduces one full beat of lane data per accepted cycle; in accumulate mode it also sums successive beats into one result that is flushed on a last-beat marker.

---
 rtl/adder_tree_acc_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/adder_tree_acc_seq.sv
// Pipelined signed adder tree over NUM_INPUTS lanes with an optional
// accumulate-over-beats output stage, flushed on a last-beat marker.
module adder_tree_acc_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 4,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS-1:0]            i_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
    input  logic                             i_en,
    input  logic                             i_acc_mode,
    input  logic                             i_last,
    output logic                             o_valid,
    output logic [ACC_WIDTH-1:0]             o_data
);

    localparam int LEVELS = $clog2(NUM_INPUTS);
    localparam int SUM_W  = DATA_WIDTH + LEVELS;

    // Bit offset of tree level s inside the packed vector holding all levels.
    function automatic int levelOffset(input int s);
        int off;
        off = 0;
        for (int t = 1; t < s; t++) begin
            off += (NUM_INPUTS >> t) * (DATA_WIDTH + t);
        end
        return off;
    endfunction

    localparam int TREE_W   = levelOffset(LEVELS + 1);
    localparam int ROOT_OFF = levelOffset(LEVELS);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    logic                             accept;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] laneData_d, laneData_q;
    logic [TREE_W-1:0]                treeSum_d, treeSum_q;
    logic [LEVELS:0]                  vldPipe_q, modePipe_q, lastPipe_q;

    logic signed [SUM_W-1:0]          rootSum;
    logic [ACC_WIDTH-1:0]             sumExt;
    logic [ACC_WIDTH-1:0]             accPlusSum;

    state_e                           state_d, state_q;
    logic [ACC_WIDTH-1:0]             acc_d, acc_q;
    logic                             oValid_d, oValid_q;
    logic [ACC_WIDTH-1:0]             oData_d, oData_q;

    assign accept     = i_en && (&i_valid);
    assign laneData_d = accept ? i_data : '0;

    for (genvar s = 1; s <= LEVELS; s++) begin : g_level
        localparam int W    = DATA_WIDTH + s;
        localparam int N    = NUM_INPUTS >> s;
        localparam int OFF  = levelOffset(s);
        localparam int POFF = levelOffset(s - 1);
        for (genvar j = 0; j < N; j++) begin : g_node
            logic [W-2:0] opA;
            logic [W-2:0] opB;
            if (s == 1) begin : g_leaf
                assign opA = laneData_q[(2*j)*DATA_WIDTH +: DATA_WIDTH];
                assign opB = laneData_q[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_inner
                assign opA = treeSum_q[POFF + (2*j)*(W-1) +: W-1];
                assign opB = treeSum_q[POFF + (2*j+1)*(W-1) +: W-1];
            end
            // One bit of sign extension per level keeps every partial sum exact.
            assign treeSum_d[OFF + j*W +: W] = {opA[W-2], opA} + {opB[W-2], opB};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            laneData_q <= '0;
            treeSum_q  <= '0;
            vldPipe_q  <= '0;
            modePipe_q <= '0;
            lastPipe_q <= '0;
        end else if (i_en) begin
            laneData_q <= laneData_d;
            treeSum_q  <= treeSum_d;
            vldPipe_q  <= {vldPipe_q[LEVELS-1:0], accept};
            modePipe_q <= {modePipe_q[LEVELS-1:0], i_acc_mode};
            lastPipe_q <= {lastPipe_q[LEVELS-1:0], i_last};
        end
    end

    assign rootSum    = treeSum_q[ROOT_OFF +: SUM_W];
    assign sumExt     = ACC_WIDTH'(rootSum);
    assign accPlusSum = acc_q + sumExt;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        oValid_d = 1'b0;
        oData_d  = '0;
        if (i_en && vldPipe_q[LEVELS]) begin
            if (!modePipe_q[LEVELS]) begin
                oValid_d = 1'b1;
                oData_d  = sumExt;
            end else if (state_q == IDLE) begin
                if (lastPipe_q[LEVELS]) begin
                    oValid_d = 1'b1;
                    oData_d  = sumExt;
                end else begin
                    acc_d   = sumExt;
                    state_d = RUN;
                end
            end else begin
                if (lastPipe_q[LEVELS]) begin
                    oValid_d = 1'b1;
                    oData_d  = accPlusSum;
                    acc_d    = '0;
                    state_d  = IDLE;
                end else begin
                    acc_d = accPlusSum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            oValid_q <= 1'b0;
            oData_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            oValid_q <= oValid_d;
            oData_q  <= oData_d;
        end
    end

    assign o_valid = oValid_q;
    assign o_data  = oData_q;

endmodule
